roi_serial_harness: RTL and testbench
=====================================

Name: roi_serial_harness

Overview:
- Parametrised serial test harness for fuzzer/minitest ROIs (BRAM, ROM, LUTRAM), successor to the fixed 256-bit shift-chain top.
- Shifts DIN_N stimulus bits in on one pin and applies them in parallel to the ROI.
- Waits a programmable settle time, captures DOUT_N ROI outputs, then shifts them out on one pin.
- Sequencing is FSM-driven with handshakes, so the pin count stays at 4-5 IOs for any ROI width.

Parameters:
- DIN_N, 256, width of the parallel stimulus bus to the ROI (≥2).
- DOUT_N, 256, width of the parallel result bus from the ROI (≥2).
- SETTLE, 4, number of cycles between stimulus apply and result capture (0..255).

Ports:
- clk  in  1  single clock; all state is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a transaction. Accepted only in IDLE.
- di  in  1  serial stimulus bit, MSB of the word first.
- di_valid  in  1  qualifies di. Accepted only in LOAD.
- do  out  1  serial result bit, MSB first.
- do_valid  out  1  do carries a valid bit this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last bit has been unloaded.
- roi_din  out  DIN_N  registered stimulus to the ROI.
- roi_dout  in  DOUT_N  ROI result, sampled in CAPTURE.

Behaviour:
- Reset (async assert, sync-deasserted externally):
  - FSM goes to IDLE; all shift registers and counters clear to 0.
  - roi_din=0, do=0, do_valid=0, busy=0, done=0.
- States: IDLE, LOAD, APPLY, CAPTURE, UNLOAD.
- IDLE:
  - start=1 -> LOAD; bit counter cleared.
  - start in any other state is ignored and does not queue.
- LOAD:
  - On each cycle with di_valid=1: din_shr <= {din_shr[DIN_N-2:0], di}; counter increments.
  - di_valid=0 stalls with no state change.
  - On the DIN_N-th accepted bit: roi_din <= {din_shr[DIN_N-2:0], di} in the same edge; go to APPLY; counter cleared.
  - roi_din holds its previous value throughout LOAD (no ripple onto the ROI).
- APPLY:
  - Lasts exactly SETTLE+1 cycles, then -> CAPTURE.
  - SETTLE=0 gives one cycle.
- CAPTURE:
  - Lasts one cycle: dout_shr <= roi_dout; -> UNLOAD.
  - The capture edge is SETTLE+2 edges after the roi_din update.
- UNLOAD:
  - do=dout_shr[DOUT_N-1] and do_valid=1 for DOUT_N consecutive cycles; shift left each cycle, filling with 0.
  - No backpressure.
  - After the last bit, done=1 for one cycle together with return to IDLE; do_valid=0 and do=0 in that cycle.
- roi_din retains the last applied stimulus after the transaction, until the next LOAD completes.
- Counters are sized $clog2(max(DIN_N,DOUT_N)+1) bits; the settle counter is 8 bits. No wrap occurs within legal parameter ranges.
- rst_n asserted mid-transaction: immediate IDLE and all outputs cleared. The partial load is discarded and there is no done pulse.
- Simultaneous start and di_valid in IDLE: only start is acted on. The bit is not captured; the first LOAD bit is taken the following cycle.

Optional Feature:
- Macro: ROI_SERIAL_HARNESS_CRC_EN.
- Defined:
  - After the DOUT_N result bits, UNLOAD emits 8 more bits with do_valid held high.
  - Those bits are a CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final xor) computed over the DOUT_N bits as shifted out.
  - Total UNLOAD length is DOUT_N+8; done follows the final CRC bit.
- Undefined: no CRC logic is present and UNLOAD is exactly DOUT_N cycles.

Test Plan (bench overrides DIN_N=8, DOUT_N=8, SETTLE=2; roi_dout driven by a model with roi_dout = ~roi_din):
- Reset then idle: hold rst_n=0 for 3 cycles, then release with no start -> all outputs 0, busy=0 for 20 cycles.
- Basic transaction:
  - Stimulus: start, then bits 1,0,1,1,0,0,1,0 with di_valid=1 continuously.
  - Response: roi_din=8'hB2 on the 8th accept edge; capture 4 edges later; do streams 0,1,0,0,1,1,0,1 (8'h4D) with do_valid=1 for 8 cycles; then one done pulse; busy falls in the same cycle.
- Stall: same stimulus with di_valid low on alternate cycles -> roi_din=8'hB2 after 16 cycles; roi_din unchanged from its prior value until then.
- Ignored start: pulse start during UNLOAD -> no second transaction; busy=0 after done.
- Mid-op reset: assert rst_n=0 after 4 loaded bits -> roi_din=0, busy=0 immediately; a new full transaction then yields 8'h4D.
- CRC build (ROI_SERIAL_HARNESS_CRC_EN): with result 8'h4D -> 16 valid bits: 8'h4D followed by CRC-8 byte 8'hE4; done on cycle 16.

Source files
------------

// File: rtl/roi_serial_harness_if.sv
// Serial pin bundle of the ROI harness: start/load handshake in, result stream and status out.
// The serial output is named do_bit because "do" is a reserved word.
interface roi_serial_harness_if;
   logic start;
   logic di;
   logic di_valid;
   logic do_bit;
   logic do_valid;
   logic busy;
   logic done;

   modport master (output start, di, di_valid, input do_bit, do_valid, busy, done);
   modport slave  (input start, di, di_valid, output do_bit, do_valid, busy, done);
endinterface

// File: rtl/roi_serial_harness.sv
// Serial-in / parallel-apply / serial-out harness for fuzzer ROIs.
// Define ROI_SERIAL_HARNESS_CRC_EN to append a CRC-8 of the result stream to UNLOAD.
module roi_serial_harness #(
   parameter int DIN_N  = 256,
   parameter int DOUT_N = 256,
   parameter int SETTLE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   roi_serial_harness_if.slave bus,
   output logic [DIN_N-1:0]    roi_din,
   input  logic [DOUT_N-1:0]   roi_dout
);

`ifdef ROI_SERIAL_HARNESS_CRC_EN
   localparam int ULEN = DOUT_N + 8;
`else
   localparam int ULEN = DOUT_N;
`endif
   localparam int MAXN = (DIN_N > ULEN) ? DIN_N : ULEN;
   localparam int CW   = $clog2(MAXN + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_APPLY, S_CAPTURE, S_UNLOAD} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [7:0]        settle_cnt;
   logic [DIN_N-1:0]  din_shr;
   logic [DOUT_N-1:0] dout_shr;
   logic              done_q;
   logic              load_last, unload_last, apply_last;
   logic              out_bit;

   assign load_last   = bus.di_valid && (cnt == CW'(DIN_N - 1));
   assign unload_last = (cnt == CW'(ULEN - 1));
   assign apply_last  = (settle_cnt == 8'(SETTLE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (bus.start) state_nxt = S_LOAD;
         S_LOAD:    if (load_last) state_nxt = S_APPLY;
         S_APPLY:   if (apply_last) state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = S_UNLOAD;
         S_UNLOAD:  if (unload_last) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Stimulus shifts into a private register; roi_din only moves on the final bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         settle_cnt <= '0;
         din_shr    <= '0;
         dout_shr   <= '0;
         roi_din    <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q     <= (state == S_UNLOAD) && unload_last;
         settle_cnt <= (state == S_APPLY) ? settle_cnt + 8'd1 : 8'd0;
         case (state)
            S_LOAD: begin
               if (bus.di_valid) begin
                  din_shr <= {din_shr[DIN_N-2:0], bus.di};
                  cnt     <= load_last ? '0 : cnt + CW'(1);
               end
               if (load_last) roi_din <= {din_shr[DIN_N-2:0], bus.di};
            end
            S_CAPTURE: begin
               dout_shr <= roi_dout;
               cnt      <= '0;
            end
            S_UNLOAD: begin
               dout_shr <= {dout_shr[DOUT_N-2:0], 1'b0};
               cnt      <= unload_last ? '0 : cnt + CW'(1);
            end
            default: cnt <= '0;
         endcase
      end
   end

`ifdef ROI_SERIAL_HARNESS_CRC_EN
   logic [7:0] crc;
   logic       crc_phase;

   assign crc_phase = (cnt >= CW'(DOUT_N));
   assign out_bit   = crc_phase ? crc[7] : dout_shr[DOUT_N-1];

   // Serial CRC-8 (x^8+x^2+x+1) over the result bits, then the register itself shifts out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= '0;
      end else if (state == S_CAPTURE) begin
         crc <= '0;
      end else if (state == S_UNLOAD) begin
         if (crc_phase) crc <= {crc[6:0], 1'b0};
         else           crc <= {crc[6:0], 1'b0} ^ ((crc[7] ^ dout_shr[DOUT_N-1]) ? 8'h07 : 8'h00);
      end
   end
`else
   assign out_bit = dout_shr[DOUT_N-1];
`endif

   assign bus.do_valid = (state == S_UNLOAD);
   assign bus.do_bit   = (state == S_UNLOAD) ? out_bit : 1'b0;
   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = done_q;

endmodule

// File: tb/tb_roi_serial_harness.sv
// Randomized scoreboard bench: expected serial bits are queued at load time and
// popped by a monitor whenever do_valid is seen.
module tb_roi_serial_harness;
   localparam int DIN_N  = 8;
   localparam int DOUT_N = 8;
   localparam int SETTLE = 2;
`ifdef ROI_SERIAL_HARNESS_CRC_EN
   localparam int ULEN = DOUT_N + 8;
`else
   localparam int ULEN = DOUT_N;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   roi_serial_harness_if bus();
   logic [DIN_N-1:0]  roi_din;
   logic [DOUT_N-1:0] roi_dout;
   assign roi_dout = ~roi_din;

   roi_serial_harness #(.DIN_N(DIN_N), .DOUT_N(DOUT_N), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .roi_din(roi_din), .roi_dout(roi_dout)
   );

   int   checks = 0;
   int   errors = 0;
   bit   exp_q[$];
   int   done_cnt = 0;
   int   ucnt = 0;
   int   txns = 0;
   logic [7:0] last_din = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // CRC as the remainder of r(x)*x^8 divided by x^8+x^2+x+1.
   function automatic logic [7:0] crc8(input logic [7:0] r);
      logic [15:0] m;
      m = {r, 8'h00};
      for (int i = 15; i >= 8; i--)
         if (m[i]) m = m ^ (16'h0107 << (i - 8));
      return m[7:0];
   endfunction

   task automatic push_expected(input logic [7:0] w);
      logic [7:0] r;
      r = ~w;
      for (int i = 7; i >= 0; i--) exp_q.push_back(r[i]);
`ifdef ROI_SERIAL_HARNESS_CRC_EN
      begin
         logic [7:0] c;
         c = crc8(r);
         for (int i = 7; i >= 0; i--) exp_q.push_back(c[i]);
      end
`endif
   endtask

   // Monitor: pops on every valid bit, checks stream length and status at done.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.do_valid) begin
            if (exp_q.size() == 0) begin
               chk("extra_bit", 32'(bus.do_bit), 32'hFFFF_FFFF);
            end else begin
               chk("do_bit", 32'(bus.do_bit), 32'(exp_q.pop_front()));
               chk("busy_unload", 32'(bus.busy), 32'd1);
            end
            ucnt++;
         end else begin
            chk("do_low", 32'(bus.do_bit), 32'd0);
         end
         if (bus.done) begin
            chk("done_len", 32'(ucnt), 32'(ULEN));
            chk("done_busy", 32'(bus.busy), 32'd0);
            chk("done_q_empty", 32'(exp_q.size()), 32'd0);
            ucnt = 0;
            done_cnt++;
         end
      end else begin
         ucnt = 0;
      end
   end

   // mode 0: continuous, 1: gap after every bit, 2: random gaps.
   task automatic load_bits(input logic [7:0] w, input int mode, input int nbits);
      int gaps;
      for (int i = 0; i < nbits; i++) begin
         gaps = (mode == 2) ? int'($urandom_range(0, 2)) : 0;
         for (int g = 0; g < gaps; g++) begin
            bus.di = 1'($urandom); bus.di_valid = 1'b0;
            chk("roi_din_hold", 32'(roi_din), 32'(last_din));
            @(negedge clk);
         end
         bus.di = w[7 - i]; bus.di_valid = 1'b1;
         chk("roi_din_hold", 32'(roi_din), 32'(last_din));
         @(negedge clk);
         if (mode == 1 && i < nbits - 1) begin
            bus.di = 1'($urandom); bus.di_valid = 1'b0;
            chk("roi_din_hold", 32'(roi_din), 32'(last_din));
            @(negedge clk);
         end
      end
      bus.di_valid = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      bus.di = 1'($urandom); bus.di_valid = 1'b1;  // must be ignored in IDLE
      @(negedge clk);
      bus.start = 1'b0; bus.di_valid = 1'b0;
   endtask

   task automatic run_txn(input logic [7:0] w, input int mode, input bit extra_start);
      int k, d0;
      pulse_start();
      load_bits(w, mode, 8);
      chk("roi_din_apply", 32'(roi_din), 32'(w));
      last_din = w;
      push_expected(w);
      txns++;
      k = 0;
      while (!bus.do_valid && k < 20) begin @(negedge clk); k++; end
      chk("capture_latency", 32'(k), 32'(SETTLE + 2));
      if (extra_start) begin
         bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
      end
      d0 = done_cnt; k = 0;
      while (done_cnt == d0 && k < 100) begin @(negedge clk); k++; end
      chk("done_seen", 32'(done_cnt), 32'(d0 + 1));
      repeat (3) begin
         @(negedge clk);
         chk("idle_after", 32'(bus.busy), 32'd0);
         chk("roi_din_retain", 32'(roi_din), 32'(last_din));
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0; bus.di = 1'b0; bus.di_valid = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("rst_busy", 32'(bus.busy), 32'd0);
         chk("rst_valid", 32'(bus.do_valid), 32'd0);
         chk("rst_done", 32'(bus.done), 32'd0);
         chk("rst_roi_din", 32'(roi_din), 32'd0);
      end

      run_txn(8'hB2, 0, 1'b0);
      run_txn(8'h3C, 0, 1'b0);
      run_txn(8'hB2, 1, 1'b0);
      run_txn(8'h5A, 0, 1'b1);

      // Abort a partial load with reset.
      pulse_start();
      load_bits(8'hB2, 0, 4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_roi_din", 32'(roi_din), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_valid", 32'(bus.do_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      last_din = '0;
      @(negedge clk);
      run_txn(8'hB2, 0, 1'b0);

      repeat (10) run_txn(8'($urandom), int'($urandom_range(0, 2)), 1'($urandom));

      repeat (5) @(negedge clk);
      chk("total_done", 32'(done_cnt), 32'(txns));
      chk("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
